// File: rtl/sdr_stream_pkg.sv
// Shared stream-arbitration types and width helpers.
package sdr_stream_pkg;

  // Arbiter FSM: either searching for the next requester or locked onto one.
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Bits needed to encode n distinct values, never less than one bit so that
  // degenerate parameterisations still produce a legal vector.
  function automatic int width_of(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: finds the first set request bit starting at ptr
// and wrapping past NUM_REQ-1 back to 0. Purely combinational.
module rr_priority_pick
  import sdr_stream_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = width_of(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  // One spare bit so ptr + offset cannot overflow before the wrap compare.
  localparam int CW = ID_WIDTH + 1;

  logic [CW-1:0] cand;

  // Walk the candidates in priority order; the first requesting one wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr} + CW'(off);
      // Explicit modulo by compare: NUM_REQ need not be a power of two.
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!found && req[cand[ID_WIDTH-1:0]]) begin
        found = 1'b1;
        idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter with burst lock feeding a single FIFO write port.
// A granted requester owns the output until it flags last or reaches
// BURST_LEN beats; out_id tags each beat with its source.
module stream_rr_arbiter
  import sdr_stream_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_LEN  = 16,
  localparam int ID_WIDTH   = width_of(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          out_last,
  output logic                          busy
);

  localparam int                 CNT_WIDTH = width_of(BURST_LEN + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  // Reject parameterisations the datapath is not built for.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("stream_rr_arbiter: NUM_REQ must be within 2..16");
  end
  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("stream_rr_arbiter: BURST_LEN must be at least 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("stream_rr_arbiter: DATA_WIDTH must be at least 1");
  end

  arb_state_t            state;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [CNT_WIDTH-1:0]  beat_cnt;

  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic                  granted;
  logic                  xfer;

  // Unpack the flat data bus into one lane per requester for clean muxing.
  logic [DATA_WIDTH-1:0] data_lane [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign data_lane[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign granted = (state == ARB_GRANT);
  assign busy    = granted;
  assign xfer    = out_valid & out_ready;

  // Wrap by compare rather than truncation so NUM_REQ=3 etc. never yields
  // an out-of-range pointer.
  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  // Pass the granted lane straight through; all other lanes see no ready.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_ready  = '0;
    out_data  = data_lane[grant_id];
    out_id    = grant_id;
    if (granted) begin
      out_valid          = in_valid[grant_id];
      out_last           = in_last[grant_id] | (beat_cnt == LAST_BEAT);
      in_ready[grant_id] = out_ready;
    end
  end

  // Grant FSM: pick in IDLE, count beats in GRANT, release on out_last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // A stalled or gapped grant simply waits; only a transfer advances.
          if (xfer) begin
            if (out_last) begin
              state    <= ARB_IDLE;
              ptr      <= next_ptr;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: three instances cover the default
// configuration, a short burst limit and a non-power-of-two requester count.
module tb_stream_rr_arbiter;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   pop_cnt [3];

  // Instance a: NUM_REQ=4, BURST_LEN=16
  logic [3:0]  a_in_valid, a_in_ready, a_in_last;
  logic [31:0] a_in_data;
  logic        a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_id;
  // Instance b: NUM_REQ=4, BURST_LEN=4
  logic [3:0]  b_in_valid, b_in_ready, b_in_last;
  logic [31:0] b_in_data;
  logic        b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_id;
  // Instance c: NUM_REQ=3, BURST_LEN=16
  logic [2:0]  c_in_valid, c_in_ready, c_in_last;
  logic [23:0] c_in_data;
  logic        c_out_valid, c_out_ready, c_out_last, c_busy;
  logic [7:0]  c_out_data;
  logic [1:0]  c_out_id;

  beat_t src_a [4][$];
  beat_t src_b [4][$];
  beat_t src_c [3][$];
  exp_t  exp_a [$];
  exp_t  exp_b [$];
  exp_t  exp_c [$];
  int    a_times [$];
  int    b_times [$];

  stream_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_id(a_out_id),
    .out_last(a_out_last), .busy(a_busy)
  );

  stream_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_id(b_out_id),
    .out_last(b_out_last), .busy(b_busy)
  );

  stream_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .BURST_LEN(16)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_id(c_out_id),
    .out_last(c_out_last), .busy(c_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait, with a cycle budget, until instance `which` has moved `target` beats.
  task automatic wait_pops(input int which, input int target, input int budget, input string name);
    int n;
    n = 0;
    while (pop_cnt[which] < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({name, "_done"}, 32'(pop_cnt[which] >= target), 32'd1);
  endtask

  // Producers: present queue heads, retire a head once it was accepted.
  initial begin
    logic [3:0] acc;
    a_in_valid = '0; a_in_last = '0; a_in_data = '0;
    forever begin
      @(negedge clk);
      acc = a_in_valid & a_in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && src_a[i].size() > 0) void'(src_a[i].pop_front());
        a_in_valid[i] = (src_a[i].size() > 0);
        a_in_last[i]  = (src_a[i].size() > 0) ? src_a[i][0].last : 1'b0;
        a_in_data[i*8 +: 8] = (src_a[i].size() > 0) ? src_a[i][0].data : 8'h00;
      end
    end
  end

  initial begin
    logic [3:0] acc;
    b_in_valid = '0; b_in_last = '0; b_in_data = '0;
    forever begin
      @(negedge clk);
      acc = b_in_valid & b_in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && src_b[i].size() > 0) void'(src_b[i].pop_front());
        b_in_valid[i] = (src_b[i].size() > 0);
        b_in_last[i]  = (src_b[i].size() > 0) ? src_b[i][0].last : 1'b0;
        b_in_data[i*8 +: 8] = (src_b[i].size() > 0) ? src_b[i][0].data : 8'h00;
      end
    end
  end

  initial begin
    logic [2:0] acc;
    c_in_valid = '0; c_in_last = '0; c_in_data = '0;
    forever begin
      @(negedge clk);
      acc = c_in_valid & c_in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (acc[i] && src_c[i].size() > 0) void'(src_c[i].pop_front());
        c_in_valid[i] = (src_c[i].size() > 0);
        c_in_last[i]  = (src_c[i].size() > 0) ? src_c[i][0].last : 1'b0;
        c_in_data[i*8 +: 8] = (src_c[i].size() > 0) ? src_c[i][0].data : 8'h00;
      end
    end
  end

  // Monitors: every beat the DUT moves is compared with the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid && a_out_ready) begin
      pop_cnt[0]++;
      a_times.push_back(cyc);
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_extra_beat: got id %0d data 0x%0h, expected no beat", a_out_id, a_out_data);
      end else begin
        e = exp_a.pop_front();
        check("a_id",   32'(a_out_id),   32'(e.id));
        check("a_data", 32'(a_out_data), 32'(e.data));
        check("a_last", 32'(a_out_last), 32'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_out_valid && b_out_ready) begin
      pop_cnt[1]++;
      b_times.push_back(cyc);
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_extra_beat: got id %0d data 0x%0h, expected no beat", b_out_id, b_out_data);
      end else begin
        e = exp_b.pop_front();
        check("b_id",   32'(b_out_id),   32'(e.id));
        check("b_data", 32'(b_out_data), 32'(e.data));
        check("b_last", 32'(b_out_last), 32'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (c_out_valid && c_out_ready) begin
      pop_cnt[2]++;
      if (exp_c.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_extra_beat: got id %0d data 0x%0h, expected no beat", c_out_id, c_out_data);
      end else begin
        e = exp_c.pop_front();
        check("c_id",   32'(c_out_id),   32'(e.id));
        check("c_data", 32'(c_out_data), 32'(e.data));
        check("c_last", 32'(c_out_last), 32'(e.last));
      end
    end
  end

  initial begin
    int push_cyc;
    int base;
    int off_b [10] = '{0, 1, 2, 3, 5, 6, 7, 8, 10, 11};
    checks = 0; errors = 0;
    pop_cnt = '{0, 0, 0};
    rst = 1'b1;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_in_ready",  32'(a_in_ready),  32'd0);
    check("rst_a_out_last",  32'(a_out_last),  32'd0);
    check("rst_a_busy",      32'(a_busy),      32'd0);
    check("rst_a_out_id",    32'(a_out_id),    32'd0);
    check("rst_b_in_ready",  32'(b_in_ready),  32'd0);
    check("rst_c_in_ready",  32'(c_in_ready),  32'd0);
    #1 rst = 1'b0;

    // Single requester: req1, 0x10..0x14, last on 0x14
    @(negedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      src_a[1].push_back('{8'h10 + 8'(k), k == 4});
      exp_a.push_back('{1, 8'h10 + 8'(k), k == 4});
    end
    a_times.delete();
    push_cyc = cyc;
    base = pop_cnt[0];
    wait_pops(0, base + 5, 50, "single");
    for (int k = 0; k < 5; k++) check("single_cycle", 32'(a_times[k]), 32'(push_cyc + 2 + k));
    check("single_busy_after", 32'(a_busy), 32'd0);

    // ptr is now 2: with req0/1/2 all asking the order must be 2,0,1
    @(negedge clk); #1;
    src_a[0].push_back('{8'h01, 1'b1});
    src_a[1].push_back('{8'h11, 1'b1});
    src_a[2].push_back('{8'h21, 1'b1});
    exp_a.push_back('{2, 8'h21, 1'b1});
    exp_a.push_back('{0, 8'h01, 1'b1});
    exp_a.push_back('{1, 8'h11, 1'b1});
    base = pop_cnt[0];
    wait_pops(0, base + 3, 50, "ptr_after_single");

    // Round robin from reset, all four valid, last every second beat
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      src_a[r].push_back('{8'(r * 16),     1'b0});
      src_a[r].push_back('{8'(r * 16 + 1), 1'b1});
      exp_a.push_back('{r, 8'(r * 16),     1'b0});
      exp_a.push_back('{r, 8'(r * 16 + 1), 1'b1});
    end
    src_a[0].push_back('{8'h02, 1'b0});
    src_a[0].push_back('{8'h03, 1'b1});
    exp_a.push_back('{0, 8'h02, 1'b0});
    exp_a.push_back('{0, 8'h03, 1'b1});
    base = pop_cnt[0];
    wait_pops(0, base + 10, 100, "round_robin");

    // Reset mid-grant: req1 burst cut during its third beat
    @(negedge clk); #1;
    for (int k = 0; k < 6; k++) src_a[1].push_back('{8'h50 + 8'(k), 1'b0});
    exp_a.push_back('{1, 8'h50, 1'b0});
    exp_a.push_back('{1, 8'h51, 1'b0});
    base = pop_cnt[0];
    wait_pops(0, base + 2, 50, "midgrant_pre");
    check("midgrant_busy",      32'(a_busy),     32'd1);
    check("midgrant_beat3",     32'(a_out_data), 32'h52);
    rst = 1'b1;
    #1;
    check("midgrant_in_ready",  32'(a_in_ready),  32'd0);
    check("midgrant_out_valid", 32'(a_out_valid), 32'd0);
    check("midgrant_busy_rst",  32'(a_busy),      32'd0);
    src_a[1].delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    src_a[2].push_back('{8'h2A, 1'b1});
    src_a[0].push_back('{8'h0A, 1'b1});
    exp_a.push_back('{0, 8'h0A, 1'b1});
    exp_a.push_back('{2, 8'h2A, 1'b1});
    base = pop_cnt[0];
    wait_pops(0, base + 2, 50, "after_reset");

    // Burst limit (instance b, BURST_LEN=4): 10 beats split 4+4+2
    @(negedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      src_b[0].push_back('{8'hA0 + 8'(k), k == 9});
      exp_b.push_back('{0, 8'hA0 + 8'(k), (k == 3) || (k == 7) || (k == 9)});
    end
    b_times.delete();
    push_cyc = cyc;
    base = pop_cnt[1];
    wait_pops(1, base + 10, 80, "burst_limit");
    for (int k = 0; k < 10; k++) check("burst_cycle", 32'(b_times[k]), 32'(push_cyc + 2 + off_b[k]));

    // Backpressure mid-burst of req2 (counter must freeze while stalled)
    @(negedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      src_b[2].push_back('{8'h20 + 8'(k), 1'b0});
      exp_b.push_back('{2, 8'h20 + 8'(k), k == 3});
    end
    base = pop_cnt[1];
    wait_pops(1, base + 2, 50, "stall_pre");
    b_out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(b_out_valid), 32'd1);
      check("stall_out_data",  32'(b_out_data),  32'h22);
      check("stall_in_ready",  32'(b_in_ready),  32'd0);
      check("stall_out_last",  32'(b_out_last),  32'd0);
      check("stall_busy",      32'(b_busy),      32'd1);
    end
    @(posedge clk); #1 b_out_ready = 1'b1;
    wait_pops(1, base + 4, 50, "stall_post");

    // Non-power-of-two wrap (instance c, NUM_REQ=3)
    @(negedge clk); #1;
    src_c[1].push_back('{8'hD1, 1'b1});
    exp_c.push_back('{1, 8'hD1, 1'b1});
    base = pop_cnt[2];
    wait_pops(2, base + 1, 50, "wrap_pre");
    @(negedge clk); #1;
    src_c[2].push_back('{8'hC0, 1'b1});
    src_c[2].push_back('{8'hC1, 1'b1});
    src_c[0].push_back('{8'hB0, 1'b1});
    exp_c.push_back('{2, 8'hC0, 1'b1});
    exp_c.push_back('{0, 8'hB0, 1'b1});
    exp_c.push_back('{2, 8'hC1, 1'b1});
    base = pop_cnt[2];
    wait_pops(2, base + 3, 50, "wrap");

    repeat (3) @(negedge clk);
    check("sb_a_empty", 32'(exp_a.size()), 32'd0);
    check("sb_b_empty", 32'(exp_b.size()), 32'd0);
    check("sb_c_empty", 32'(exp_c.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one sample FIFO (fifo_sync write port) between NUM_REQ producer streams.
- Round-robin arbitration with burst lock: a granted requester keeps the FIFO until it signals last or hits BURST_LEN beats.
- Output drives the FIFO in_valid/in_ready/in_data directly; out_id tags the source so the consumer can demultiplex.

Parameters:
- NUM_REQ, 4, number of requesters (2..16, need not be a power of two).
- DATA_WIDTH, 8, beat width; must equal the FIFO WRITE_DATA_WIDTH.
- BURST_LEN, 16, maximum beats per grant (>=1).
- ID_WIDTH, derived localparam, max(1, clog2(NUM_REQ)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_REQ  per-requester beat valid.
- in_ready  out  NUM_REQ  per-requester beat accepted.
- in_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  NUM_REQ  requester marks its final beat; releases grant.
- out_valid  out  1  to FIFO in_valid.
- out_ready  in  1  from FIFO in_ready.
- out_data  out  DATA_WIDTH  to FIFO in_data.
- out_id  out  ID_WIDTH  index of the granted requester.
- out_last  out  1  beat ends the current grant (in_last or burst limit).
- busy  out  1  high while in GRANT state.

Behaviour:
- Reset: state=IDLE, ptr=0, grant_id=0, beat_cnt=0; out_valid=0, in_ready=0 all bits, out_last=0, busy=0, out_id=0. out_data unspecified (don't-care) while out_valid=0.
- Reset mid-grant: asynchronous drop to IDLE; no beat accepted in that cycle; the partial burst is abandoned, not resumed.
- Transfer rule: a beat moves when out_valid & out_ready.
- States:
  - IDLE: if any in_valid, select the first set bit searching from ptr upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ...). Register grant_id and go to GRANT with beat_cnt=0. No beat passes in IDLE.
  - GRANT: combinational pass-through. out_valid = in_valid[grant_id]; out_data = slice[grant_id]; in_ready[grant_id] = out_ready; every other in_ready bit = 0; out_id = grant_id.
    - out_last = in_last[grant_id] | (beat_cnt == BURST_LEN-1).
    - On a transfer: beat_cnt++. If out_last, go to IDLE and set ptr = (grant_id+1) mod NUM_REQ, using an explicit compare for non-power-of-two NUM_REQ, not a bit-truncation wrap.
    - If the granted requester drops in_valid, hold the grant; no timeout. Producers are required to deliver a burst without gaps longer than the FIFO can tolerate.
- Latency: grant registered one cycle after the request is seen in IDLE. The first beat can transfer in the following cycle, so there is one dead cycle between consecutive grants. Peak throughput is BURST_LEN/(BURST_LEN+1).
- FIFO full (out_ready=0): out_valid holds, in_ready=0, beat_cnt is unchanged, and the grant persists.
- Simultaneous in_last and burst limit on the same beat: single release, ptr advances once.
- BURST_LEN=1: every beat is out_last, giving pure per-beat round robin.
- beat_cnt width = clog2(BURST_LEN+1); it never exceeds BURST_LEN-1.
- Fairness: a requester that becomes valid waits at most (NUM_REQ-1) grants.

Decomposition:
- Shared package sdr_stream_pkg: arb_state_t enum {ARB_IDLE, ARB_GRANT}; a clog2-based width helper function for ID_WIDTH and the counter width.
- One sub-module rr_priority_pick: combinational, takes req[NUM_REQ] and ptr, returns found and idx. It is reused by any later scheduler.
- The FIFO itself stays outside; the integration level connects out_* to fifo_sync in_*.

Test Plan:
- Single requester: req1 sends 5 beats 0x10..0x14 with last on 0x14, out_ready=1. Expect 1 IDLE cycle, then 5 consecutive transfers with out_id=1, out_last only on 0x14, and ptr=2 afterwards.
- Burst limit: BURST_LEN=4, req0 streams 10 beats with no last. Expect grants of 4+4+2 beats, out_last on beats 4, 8 and at the end (last asserted on beat 10), and a dead cycle between grants.
- Round robin, all four valid continuously with last on every 2nd beat, starting from reset. Expect the grant order 0,1,2,3,0 and the out_id sequence 0,0,1,1,2,2,3,3,0,0.
- Backpressure: out_ready=0 for 3 cycles mid-burst of req2. Expect out_valid held, out_data stable, in_ready[2]=0, beat_cnt frozen, and the burst completing with no loss or duplication.
- Non-power-of-two wrap: NUM_REQ=3, only req2 and req0 valid. Expect alternating out_id 2,0,2 with no grant ever reaching 3.
- Reset mid-grant: assert rst during beat 3 of req1. Expect all in_ready=0, out_valid=0 and busy=0 immediately. After release, ptr=0 and the first grant goes to the lowest valid index.
